// File: rtl/mem_access_stage.sv
// Pipeline memory stage: passes ALU results through, runs loads/stores over a
// req/ack data bus, extends load data and drives the registered writeback triple.
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_wreg,
  input  logic [4:0]        ex_waddr,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [3:0]        ex_mem_op,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_stall_req,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_ack,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic              misalign_exc,
  output logic              wb_we,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  // Bus handshake: dbus_req rises with every dbus_* field valid and all of
  // them stay frozen until the edge that samples dbus_ack high; that edge
  // ends the access. dbus_ack while no request is open is ignored.

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {S_IDLE = 1'b0, S_BUS = 1'b1} state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]        r_op;
  logic              r_wreg;
  logic [4:0]        r_waddr;
  logic [1:0]        r_off;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic              w_sz_b;
  logic              w_sz_h;
  logic              w_sz_w;
  logic [1:0]        w_off;
  logic              w_misalign;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [7:0]        w_lane_b;
  logic [15:0]       w_lane_h;
  logic [DATA_W-1:0] w_load_data;
  logic              r_is_load;

  assign w_off      = ex_alu_result[1:0];
  assign w_is_load  = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LW);
  assign w_is_store = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);
  assign w_is_mem   = w_is_load || w_is_store;
  assign w_sz_b     = (ex_mem_op == OP_LB) || (ex_mem_op == OP_LBU) || (ex_mem_op == OP_SB);
  assign w_sz_h     = (ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH);
  assign w_sz_w     = (ex_mem_op == OP_LW) || (ex_mem_op == OP_SW);
  assign w_misalign = (w_sz_h && w_off[0]) || (w_sz_w && (w_off != 2'b00));

  assign mem_stall_req = (r_state == S_BUS);
  assign r_is_load     = (r_op >= OP_LB) && (r_op <= OP_LW);

  // Lane enables and lane-replicated store data for the access being issued.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = ex_store_data;
    if (w_sz_b) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{ex_store_data[7:0]}};
    end else if (w_sz_h) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{ex_store_data[15:0]}};
    end else if (w_sz_w) begin
      w_be    = 4'b1111;
    end
  end

  // Little-endian lane select and extension for the outstanding load.
  always_comb begin
    w_lane_b = dbus_rdata[7:0];
    case (r_off)
      2'd0: w_lane_b = dbus_rdata[7:0];
      2'd1: w_lane_b = dbus_rdata[15:8];
      2'd2: w_lane_b = dbus_rdata[23:16];
      2'd3: w_lane_b = dbus_rdata[31:24];
      default: w_lane_b = dbus_rdata[7:0];
    endcase
    w_lane_h = r_off[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    w_load_data = dbus_rdata;
    case (r_op)
      OP_LB:   w_load_data = {{24{w_lane_b[7]}}, w_lane_b};
      OP_LBU:  w_load_data = {24'd0, w_lane_b};
      OP_LH:   w_load_data = {{16{w_lane_h[15]}}, w_lane_h};
      OP_LHU:  w_load_data = {16'd0, w_lane_h};
      default: w_load_data = dbus_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ex_valid && w_is_mem && !w_misalign) w_next = S_BUS;
      S_BUS:   if (dbus_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbus_req     <= 1'b0;
      dbus_we      <= 1'b0;
      dbus_addr    <= '0;
      dbus_be      <= 4'b0000;
      dbus_wdata   <= '0;
      misalign_exc <= 1'b0;
      wb_we        <= 1'b0;
      wb_addr      <= 5'd0;
      wb_data      <= '0;
      r_op         <= 4'd0;
      r_wreg       <= 1'b0;
      r_waddr      <= 5'd0;
      r_off        <= 2'd0;
    end else begin
      wb_we        <= 1'b0;
      misalign_exc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex_valid) begin
            if (!w_is_mem) begin
              wb_we   <= ex_wreg;
              wb_addr <= ex_waddr;
              wb_data <= ex_alu_result;
            end else if (w_misalign) begin
              misalign_exc <= 1'b1;
            end else begin
              dbus_req   <= 1'b1;
              dbus_we    <= w_is_store;
              dbus_addr  <= {ex_alu_result[ADDR_W-1:2], 2'b00};
              dbus_be    <= w_be;
              dbus_wdata <= w_wdata;
              r_op       <= ex_mem_op;
              r_wreg     <= ex_wreg;
              r_waddr    <= ex_waddr;
              r_off      <= w_off;
            end
          end
        end
        S_BUS: begin
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            if (r_is_load) begin
              wb_we   <= r_wreg;
              wb_addr <= r_waddr;
              wb_data <= w_load_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage pipeline. It sits between the EX/MEM latch and the register file write port.
- Takes one instruction per accepted cycle from EX. Non-memory results pass through. Loads and stores run over a req/ack data bus, and load data is extended.
- Drives the registered writeback triple wb_we/wb_addr/wb_data straight into the register file.
- Raises a stall request to pipeline control while a bus access is outstanding.

Parameters:
- ADDR_W, 32, data bus address width
- DATA_W, 32, word width; fixed at 32, byte lanes = 4

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  instruction present from EX
- ex_wreg  in  1  instruction writes a GPR
- ex_waddr  in  5  destination GPR
- ex_alu_result  in  32  ALU result, or effective address for memory ops
- ex_mem_op  in  4  0=NONE 1=LB 2=LBU 3=LH 4=LHU 5=LW 6=SB 7=SH 8=SW; others treated as NONE
- ex_store_data  in  32  store source register
- mem_stall_req  out  1  upstream must hold ex_* stable
- dbus_req  out  1  bus request
- dbus_we  out  1  1=store
- dbus_addr  out  32  word-aligned address
- dbus_be  out  4  byte enables, bit i = byte lane i
- dbus_wdata  out  32  store data, lane-replicated
- dbus_ack  in  1  access complete; rdata valid for loads
- dbus_rdata  in  32  load word
- misalign_exc  out  1  one-cycle pulse on a misaligned access
- wb_we  out  1  register file write enable
- wb_addr  out  5  register file write address
- wb_data  out  32  register file write data

Behaviour:
- Reset: rst high at a clk edge clears all of the following, regardless of state:
  - state=IDLE
  - outputs dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata, wb_we, wb_addr, wb_data, misalign_exc = 0
  - internal latches = 0
- Reset mid-access abandons the access. A dbus_ack arriving after reset is ignored.
- States: IDLE and BUS. mem_stall_req = (state==BUS), combinational.
- ex_* is sampled only at edges where state==IDLE and ex_valid=1.
- IDLE, NONE op:
  - next edge: wb_we=ex_wreg, wb_addr=ex_waddr, wb_data=ex_alu_result
  - stay in IDLE, so latency is 1 cycle
- IDLE, memory op, aligned:
  - latch op, waddr, wreg and byte offset a=ex_alu_result[1:0]
  - next edge: dbus_req=1, dbus_addr={ex_alu_result[31:2],2'b00}, dbus_we=(op is store), go to BUS; wb_we=0 that cycle
- Byte enables and store data:
  - LB/LBU/SB: be=4'b0001<<a
  - LH/LHU/SH: be=a[1]?4'b1100:4'b0011
  - LW/SW: be=4'b1111
  - SB wdata = byte replicated 4x; SH wdata = half replicated 2x; SW wdata = word
- Misaligned access: halfword with a[0]=1, or word with a!=0.
  - no bus access; state stays IDLE
  - next edge: misalign_exc=1 for one cycle, wb_we=0
- BUS:
  - dbus_req and all dbus_* fields held stable until dbus_ack is sampled high
  - on the ack edge: dbus_req=0, go to IDLE
  - load: wb_we=latched wreg, wb_addr=latched waddr, wb_data=extended lane data
  - store: wb_we=0
- Load extension, little-endian:
  - LB sign-extends byte lane a; LBU zero-extends it
  - LH sign-extends half a[1]; LHU zero-extends it
  - LW passes the word through
- Zero-wait bus (ack in the first req cycle) gives load latency 2 cycles from acceptance to wb.
- Back-to-back: the instruction EX holds during BUS is accepted in the first IDLE cycle after the ack, so no instruction is lost or duplicated.
- wb_we is a one-cycle pulse per completing instruction and is 0 in all idle cycles.
- wb_addr=0 with wreg=1 is passed through unchanged; the register file discards it.
- dbus_ack while in IDLE is ignored.

Test Plan:
- Reset then NONE op:
  - rst=1 2 cycles -> all outputs 0
  - ex NONE, wreg=1, waddr=5, result=0x1234 -> next cycle wb_we=1, wb_addr=5, wb_data=0x1234, stall never asserted
- LB with 3-cycle ack latency:
  - addr=0x103, rdata=0x80FF_0000
  - -> dbus_addr=0x100, be=1000, stall high 3 cycles, then wb_data=0xFFFF_FF80
  - same access as LBU -> wb_data=0x0000_0080
- SH:
  - addr=0x202, store_data=0xDEAD_BEEF
  - -> dbus_we=1, be=1100, wdata=0xBEEF_BEEF, wb_we stays 0
- Misaligned LW:
  - addr=0x301 -> dbus_req never asserted, misalign_exc pulses one cycle, wb_we=0
- Back-to-back:
  - LW held by zero-wait ack, then NONE op held during stall
  - -> two wb pulses on consecutive cycles, correct addr/data each, no duplicate
- Reset in BUS:
  - assert rst while dbus_req=1, ack arrives after reset
  - -> dbus_req=0 after the reset edge, no wb pulse, state IDLE
